// File: rtl/sklansky_adder_arbiter_pkg.sv
// rtl/sklansky_adder_arbiter_pkg.sv - shared types and constants for the shared-adder arbiter
// Optional feature macro: SKLANSKY_ARB_SATURATE_EN
package sklansky_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DATA_W      = 8;
    localparam int DEF_NUM_REQ = 4;

    // Pointer starts on the last lane so lane 0 is searched first after reset
    function automatic int rr_ptr_reset(input int num_req);
        return num_req - 1;
    endfunction

endpackage

// File: rtl/sklansky_adder_arbiter_if.sv
// rtl/sklansky_adder_arbiter_if.sv - request, adder and response signal bundle
// Optional feature macro: SKLANSKY_ARB_SATURATE_EN
interface sklansky_adder_arbiter_if
    import sklansky_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [DATA_W-1:0]         add_a;
    logic [DATA_W-1:0]         add_b;
    logic [DATA_W-1:0]         add_sum;
    logic                      add_cout;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_sum;
    logic                      rsp_cout;
    logic [ID_W-1:0]           rsp_id;
    logic                      busy;

    modport slave (
        input  req_valid, req_a, req_b, add_sum, add_cout, rsp_ready,
        output req_ready, add_a, add_b, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy
    );

    modport master (
        output req_valid, req_a, req_b, add_sum, add_cout, rsp_ready,
        input  req_ready, add_a, add_b, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy
    );
endinterface

// File: rtl/sklansky_adder_arbiter_rr_arbiter.sv
// rtl/sklansky_adder_arbiter_rr_arbiter.sv - combinational round-robin grant search
// Optional feature macro: SKLANSKY_ARB_SATURATE_EN
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_idx,
    output logic               o_any_grant
);
    logic [ID_W-1:0] w_idx;

    // Scan lanes ptr+1 .. ptr+NUM_REQ (wrapping); the first valid lane wins
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_grant = 1'b0;
        w_idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = ID_W'((int'(i_rr_ptr) + k) % NUM_REQ);
            if (!o_any_grant && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
                o_any_grant    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sklansky_adder_arbiter.sv
// rtl/sklansky_adder_arbiter.sv - shares one external 8-bit adder among NUM_REQ lanes
// Optional feature macro: SKLANSKY_ARB_SATURATE_EN
module sklansky_adder_arbiter
    import sklansky_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sklansky_adder_arbiter_if.slave  bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    state_t              r_state;
    state_t              w_next_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_op_a;
    logic [DATA_W-1:0]   r_op_b;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_sum;
    logic                r_rsp_cout;
    logic [ID_W-1:0]     r_rsp_id;

    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_W-1:0]     w_grant_idx;
    logic                w_any_grant;
    logic [DATA_W-1:0]   w_lane_a;
    logic [DATA_W-1:0]   w_lane_b;
    logic [DATA_W-1:0]   w_sum_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .i_req       (bus.req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any_grant (w_any_grant)
    );

    assign w_lane_a = bus.req_a[w_grant_idx*DATA_W +: DATA_W];
    assign w_lane_b = bus.req_b[w_grant_idx*DATA_W +: DATA_W];

`ifdef SKLANSKY_ARB_SATURATE_EN
    // Clamp so an accumulating membrane potential pins at full scale instead of wrapping
    assign w_sum_next = bus.add_cout ? {DATA_W{1'b1}} : bus.add_sum;
`else
    assign w_sum_next = bus.add_sum;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any_grant) w_next_state = EXEC;
            EXEC:    w_next_state = RESP;
            RESP:    if (r_rsp_valid && bus.rsp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= ID_W'(rr_ptr_reset(NUM_REQ));
            r_id        <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_sum   <= '0;
            r_rsp_cout  <= 1'b0;
            r_rsp_id    <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (w_any_grant) begin
                        r_op_a   <= w_lane_a;
                        r_op_b   <= w_lane_b;
                        r_rr_ptr <= w_grant_idx;
                        r_id     <= w_grant_idx;
                    end
                end
                EXEC: begin
                    r_rsp_sum   <= w_sum_next;
                    r_rsp_cout  <= bus.add_cout;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (r_rsp_valid && bus.rsp_ready) r_rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (r_state == IDLE) ? w_grant : '0;
    assign bus.add_a     = r_op_a;
    assign bus.add_b     = r_op_b;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_sum   = r_rsp_sum;
    assign bus.rsp_cout  = r_rsp_cout;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_sklansky_adder_arbiter.sv
// tb/tb_sklansky_adder_arbiter.sv - scoreboard bench for the shared-adder arbiter
// Optional feature macro: SKLANSKY_ARB_SATURATE_EN
module tb_sklansky_adder_arbiter;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic [1:0] id;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   last_rsp = -1;
    logic cad_on = 1'b0;
    exp_t q[$];

    sklansky_adder_arbiter_if #(.NUM_REQ(4)) bus ();

    sklansky_adder_arbiter #(.NUM_REQ(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // External combinational adder shared by all lanes
    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] es(input logic [7:0] wrap, input logic c);
`ifdef SKLANSKY_ARB_SATURATE_EN
        return c ? 8'hFF : wrap;
`else
        return wrap;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_sum",  32'(bus.rsp_sum),  32'(e.sum));
                chk("rsp_cout", 32'(bus.rsp_cout), 32'(e.cout));
                chk("rsp_id",   32'(bus.rsp_id),   32'(e.id));
            end
            if (cad_on) begin
                if (last_rsp >= 0) chk("rsp_cadence", 32'(cyc - last_rsp), 32'd3);
                last_rsp = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int lane, input logic v, input logic [7:0] a, input logic [7:0] b);
        bus.req_valid[lane]      = v;
        bus.req_a[lane*8 +: 8]   = a;
        bus.req_b[lane*8 +: 8]   = b;
    endtask

    // Wait for the next grant, check which lane won, queue its response, step past accept edge
    task automatic grant(input int lane, input logic [7:0] s, input logic c);
        int t;
        exp_t e;
        t = 0;
        #1;
        while (bus.req_ready == 4'b0 && t < 20) begin
            @(posedge clk);
            #2;
            t++;
        end
        chk($sformatf("grant_lane%0d", lane), 32'(bus.req_ready), 32'(4'b1 << lane));
        e.sum  = s;
        e.cout = c;
        e.id   = 2'(lane);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int t = 0; t < 30 && q.size() != 0; t++) tick();
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        tick();
        tick();
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_add_a",     32'(bus.add_a),     32'd0);
        chk("rst_add_b",     32'(bus.add_b),     32'd0);
        chk("rst_rsp_sum",   32'(bus.rsp_sum),   32'd0);
        chk("rst_rsp_cout",  32'(bus.rsp_cout),  32'd0);
        chk("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single request, latency
        set_lane(0, 1'b1, 8'h3C, 8'h05);
        grant(0, 8'h41, 1'b0);
        set_lane(0, 1'b0, 8'h00, 8'h00);
        #1;
        chk("exec_busy",      32'(bus.busy),      32'd1);
        chk("exec_add_a",     32'(bus.add_a),     32'h3C);
        chk("exec_add_b",     32'(bus.add_b),     32'h05);
        chk("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("exec_req_ready", 32'(bus.req_ready), 32'd0);
        tick();
        chk("lat_rsp_valid",  32'(bus.rsp_valid), 32'd1);
        tick();
        chk("post_rsp_busy",  32'(bus.busy),      32'd0);
        drain();

        // Overflow on lane 2
        set_lane(2, 1'b1, 8'hF0, 8'h20);
        grant(2, es(8'h10, 1'b1), 1'b1);
        set_lane(2, 1'b0, 8'h00, 8'h00);
        drain();

        // Fairness with all lanes held valid
        do_reset();
        set_lane(0, 1'b1, 8'h10, 8'h01);
        set_lane(1, 1'b1, 8'h80, 8'h80);
        set_lane(2, 1'b1, 8'hFF, 8'h01);
        set_lane(3, 1'b1, 8'h7F, 8'h01);
        cad_on   = 1'b1;
        last_rsp = -1;
        grant(0, 8'h11, 1'b0);
        grant(1, es(8'h00, 1'b1), 1'b1);
        grant(2, es(8'h00, 1'b1), 1'b1);
        grant(3, 8'h80, 1'b0);
        grant(0, 8'h11, 1'b0);
        grant(1, es(8'h00, 1'b1), 1'b1);
        bus.req_valid = '0;
        drain();
        cad_on = 1'b0;

        // Backpressure holds RESP and blocks new grants
        bus.rsp_ready = 1'b0;
        set_lane(1, 1'b1, 8'h55, 8'hAA);
        grant(1, 8'hFF, 1'b0);
        set_lane(1, 1'b0, 8'h00, 8'h00);
        tick();
        set_lane(0, 1'b1, 8'h01, 8'h02);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_sum",   32'(bus.rsp_sum),   32'hFF);
            chk("bp_rsp_cout",  32'(bus.rsp_cout),  32'd0);
            chk("bp_rsp_id",    32'(bus.rsp_id),    32'd1);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_busy",      32'(bus.busy),      32'd1);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
        chk("bp_release_busy",  32'(bus.busy),      32'd0);
        grant(0, 8'h03, 1'b0);
        set_lane(0, 1'b0, 8'h00, 8'h00);
        drain();

        // Reset while in EXEC discards the operation and the pointer
        set_lane(2, 1'b1, 8'h11, 8'h22);
        #1;
        chk("rx_grant_lane2", 32'(bus.req_ready), 32'b0100);
        tick();
        set_lane(2, 1'b0, 8'h00, 8'h00);
        rst_n = 1'b0;
        #1;
        chk("rx_busy_exec", 32'(bus.busy), 32'd1);
        tick();
        rst_n = 1'b1;
        chk("rx_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rx_busy",      32'(bus.busy),      32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rx_idle_valid", 32'(bus.rsp_valid), 32'd0);
        end
        set_lane(3, 1'b1, 8'hC8, 8'h64);
        set_lane(0, 1'b1, 8'h20, 8'h30);
        grant(0, 8'h50, 1'b0);
        set_lane(0, 1'b0, 8'h00, 8'h00);
        grant(3, es(8'h2C, 1'b1), 1'b1);
        set_lane(3, 1'b0, 8'h00, 8'h00);
        drain();

        // Sparse traffic on lane 1, then lane 0 joins
        set_lane(1, 1'b1, 8'h01, 8'h01);
        grant(1, 8'h02, 1'b0);
        grant(1, 8'h02, 1'b0);
        grant(1, 8'h02, 1'b0);
        set_lane(0, 1'b1, 8'h04, 8'h05);
        grant(0, 8'h09, 1'b0);
        set_lane(0, 1'b0, 8'h00, 8'h00);
        grant(1, 8'h02, 1'b0);
        set_lane(1, 1'b0, 8'h00, 8'h00);
        drain();

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
